// File: rtl/packet_filter_pkg.sv
// packet_filter_pkg: shared types for the store-and-forward packet filter.
// Word layout is width-dependent, so it lives in the top module.
package packet_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    DROP
  } filter_state_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST packet stream bundle.
// sink consumes a stream, src produces one.
interface avalon_st_if #(
  parameter int DWIDTH        = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int EMPTY_WIDTH   = 3
);

  logic [DWIDTH-1:0]        data;
  logic                     valid;
  logic                     ready;
  logic                     startofpacket;
  logic                     endofpacket;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic [CHANNEL_WIDTH-1:0] channel;

  modport sink (
    input  data, valid, startofpacket,
    input  endofpacket, empty, channel,
    output ready
  );

  modport src (
    output data, valid, startofpacket,
    output endofpacket, empty, channel,
    input  ready
  );

endinterface

// File: rtl/pkt_buf_ram.sv
// pkt_buf_ram: simple dual-port RAM, registered read.
// The array has no reset so it maps onto block memory.
module pkt_buf_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_re)
      r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/packet_filter.sv
// packet_filter: buffers whole packets, forwards those whose eop channel
// is nonzero, discards the rest and pulses a keep/drop status per packet.
module packet_filter
  import packet_filter_pkg::*;
#(
  parameter int AST_DWIDTH    = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int BUF_DEPTH     = 256,
  parameter int EMPTY_WIDTH   = $clog2(AST_DWIDTH/8)
) (
  input  logic       clk_i,
  input  logic       srst_i,
  avalon_st_if.sink  sink_if,
  avalon_st_if.src   src_if,
  output logic       pkt_kept_o,
  output logic       pkt_drop_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = ptr_width(BUF_DEPTH);

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(BUF_DEPTH);
  localparam ptr_t ONE     = ptr_t'(1);

  typedef struct packed {
    logic [AST_DWIDTH-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
  } buf_word_t;

  localparam int WW = $bits(buf_word_t);

  filter_state_t r_state;
  filter_state_t w_state_nxt;

  ptr_t r_wr_ptr;
  ptr_t r_commit_ptr;
  ptr_t r_rd_ptr;
  ptr_t r_raddr;
  ptr_t w_wr_nxt;
  ptr_t w_cm_nxt;
  ptr_t w_base;
  ptr_t w_fill;
  ptr_t w_pkt_len;

  logic w_sink_rdy;
  logic w_acc;
  logic w_ch_hit;
  logic w_start;
  logic w_we;
  logic w_kept;
  logic w_drop;
  logic r_kept;
  logic r_drop;

  logic [AW-1:0] w_waddr;
  buf_word_t     w_wword;
  buf_word_t     w_rword;
  buf_word_t     r_out;
  buf_word_t     r_skid;

  logic       r_ov;
  logic       r_sv;
  logic       r_pend;
  logic       w_pop;
  logic       w_rd;
  logic [1:0] w_occ;

  // rd_ptr retires a word only once it has left src
  assign w_fill     = r_wr_ptr - r_rd_ptr;
  assign w_pkt_len  = r_wr_ptr - r_commit_ptr;
  assign w_sink_rdy = !srst_i &&
                      (r_state == DROP || w_fill != DEPTH_P);
  assign w_acc      = sink_if.valid && w_sink_rdy;
  assign w_ch_hit   = |sink_if.channel;

  assign sink_if.ready = w_sink_rdy;

  assign w_wword.data  = sink_if.data;
  assign w_wword.sop   = sink_if.startofpacket;
  assign w_wword.eop   = sink_if.endofpacket;
  assign w_wword.empty = sink_if.empty;
  assign w_waddr       = w_base[AW-1:0];

  always_comb begin
    w_we        = 1'b0;
    w_start     = 1'b0;
    w_base      = r_wr_ptr;
    w_wr_nxt    = r_wr_ptr;
    w_cm_nxt    = r_commit_ptr;
    w_state_nxt = r_state;
    w_kept      = 1'b0;
    w_drop      = 1'b0;
    if (w_acc) begin
      unique case (r_state)
        IDLE: w_start = sink_if.startofpacket;
        STORE: begin
          if (sink_if.startofpacket) begin
            w_drop  = 1'b1;
            w_base  = r_commit_ptr;
            w_start = 1'b1;
          end else begin
            w_we     = 1'b1;
            w_wr_nxt = r_wr_ptr + ONE;
            if (sink_if.endofpacket) begin
              w_state_nxt = IDLE;
              if (w_ch_hit) begin
                w_cm_nxt = r_wr_ptr + ONE;
                w_kept   = 1'b1;
              end else begin
                w_wr_nxt = r_commit_ptr;
                w_drop   = 1'b1;
              end
            end else if (w_pkt_len == DEPTH_P - ONE) begin
              // this beat fills the buffer and more follow
              w_wr_nxt    = r_commit_ptr;
              w_state_nxt = DROP;
            end
          end
        end
        DROP: begin
          if (sink_if.startofpacket) begin
            w_drop  = 1'b1;
            w_start = 1'b1;
          end else if (sink_if.endofpacket) begin
            w_drop      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    if (w_start) begin
      w_we = 1'b1;
      if (sink_if.endofpacket) begin
        w_state_nxt = IDLE;
        if (w_ch_hit) begin
          w_wr_nxt = w_base + ONE;
          w_cm_nxt = w_base + ONE;
          w_kept   = 1'b1;
        end else begin
          w_wr_nxt = w_base;
          w_drop   = 1'b1;
        end
      end else begin
        w_wr_nxt    = w_base + ONE;
        w_state_nxt = STORE;
      end
    end
  end

  // Fetch only while out reg + skid can absorb the in-flight word
  assign w_pop = r_ov && src_if.ready;
  assign w_occ = {1'b0, r_ov} + {1'b0, r_sv} + {1'b0, r_pend};
  assign w_rd  = (r_raddr != r_commit_ptr) &&
                 ((w_occ - {1'b0, w_pop}) < 2'd2);

  pkt_buf_ram #(
    .DW (WW),
    .AW (AW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wword),
    .i_re    (w_rd),
    .i_raddr (r_raddr[AW-1:0]),
    .o_rdata (w_rword)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_raddr      <= '0;
      r_kept       <= 1'b0;
      r_drop       <= 1'b0;
      r_pend       <= 1'b0;
      r_ov         <= 1'b0;
      r_sv         <= 1'b0;
      r_out        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_nxt;
      r_commit_ptr <= w_cm_nxt;
      r_kept       <= w_kept;
      r_drop       <= w_drop;
      r_pend       <= w_rd;
      if (w_rd)
        r_raddr <= r_raddr + ONE;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ONE;
        if (r_sv) begin
          r_out <= r_skid;
          if (r_pend)
            r_skid <= w_rword;
          else
            r_sv <= 1'b0;
        end else if (r_pend) begin
          r_out <= w_rword;
        end else begin
          r_ov <= 1'b0;
        end
      end else if (r_pend) begin
        if (!r_ov) begin
          r_out <= w_rword;
          r_ov  <= 1'b1;
        end else begin
          r_skid <= w_rword;
          r_sv   <= 1'b1;
        end
      end
    end
  end

  assign src_if.valid         = r_ov;
  assign src_if.data          = r_out.data;
  assign src_if.startofpacket = r_out.sop;
  assign src_if.endofpacket   = r_out.eop;
  assign src_if.empty         = r_out.empty;
  assign src_if.channel       = CHANNEL_WIDTH'(0);

  assign pkt_kept_o = r_kept;
  assign pkt_drop_o = r_drop;

endmodule

// File: tb/tb_packet_filter.sv
// tb_packet_filter: directed scoreboard bench for packet_filter
// with an 8-word buffer.
module tb_packet_filter;

  localparam int DW    = 64;
  localparam int EW    = 3;
  localparam int DEPTH = 8;

  typedef logic [DW+EW+1:0] v_t;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  logic kept;
  logic drop;

  avalon_st_if #(.DWIDTH(DW), .CHANNEL_WIDTH(1), .EMPTY_WIDTH(EW)) snk ();
  avalon_st_if #(.DWIDTH(DW), .CHANNEL_WIDTH(1), .EMPTY_WIDTH(EW)) src ();

  packet_filter #(
    .AST_DWIDTH    (DW),
    .CHANNEL_WIDTH (1),
    .BUF_DEPTH     (DEPTH)
  ) dut (
    .clk_i      (clk),
    .srst_i     (srst),
    .sink_if    (snk),
    .src_if     (src),
    .pkt_kept_o (kept),
    .pkt_drop_o (drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_kept = 0;
  int n_drop = 0;
  int stalls = 0;
  v_t sb[$];

  logic tog       = 1'b0;
  logic tog_en    = 1'b0;
  logic rdy_fixed = 1'b1;

  assign src.ready = tog_en ? tog : rdy_fixed;

  always @(posedge clk) tog <= ~tog;

  always @(posedge clk) begin
    if (kept) n_kept++;
    if (drop) n_drop++;
  end

  task automatic check(input string tag, input v_t obs, input v_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  v_t   cur;
  v_t   held;
  logic hold = 1'b0;

  assign cur = {src.data, src.startofpacket, src.endofpacket, src.empty};

  always @(negedge clk) begin
    if (srst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("src_hold_valid", v_t'(src.valid), v_t'(1));
        check("src_hold_data", cur, held);
      end
      if (src.valid && src.ready) begin
        if (sb.size() == 0)
          check("src_extra_beat", v_t'(src.valid), v_t'(0));
        else
          check("src_beat", cur, sb.pop_front());
      end
      hold = src.valid && !src.ready;
      held = cur;
    end
  end

  function automatic logic [DW-1:0] pat(input int id, input int i);
    return {8'hA5, id[23:0], i[31:0]};
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic s,
                           input logic e, input logic [EW-1:0] em,
                           input logic ch, input logic push);
    int w;
    w = 0;
    snk.valid = 1'b1;
    snk.data = d;
    snk.startofpacket = s;
    snk.endofpacket = e;
    snk.empty = em;
    snk.channel = ch;
    @(negedge clk);
    while (!snk.ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    stalls += w;
    if (w >= 200)
      check("snk_ready_timeout", v_t'(snk.ready), v_t'(1));
    else if (push)
      sb.push_back({d, s, e, em});
    @(posedge clk);
    #1;
    snk.valid = 1'b0;
    snk.startofpacket = 1'b0;
    snk.endofpacket = 1'b0;
    snk.channel = 1'b0;
  endtask

  task automatic send_pkt(input int id, input int n,
                          input logic ch, input logic push);
    for (int i = 0; i < n; i++)
      send_beat(pat(id, i), i == 0, i == n - 1,
                (i == n - 1) ? EW'(id) : '0,
                (i == n - 1) ? ch : 1'b0, push);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // called right after the eop beat was accepted
  task automatic lat_check(input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, v_t'(kept), v_t'(1));
    check({tag, "_q1"}, v_t'(src.valid), v_t'(0));
    @(negedge clk);
    check({tag, "_pulse_end"}, v_t'(kept), v_t'(0));
    check({tag, "_q2"}, v_t'(src.valid), v_t'(0));
    @(negedge clk);
    check({tag, "_first"}, v_t'(src.valid), v_t'(1));
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check(tag, v_t'(sb.size()), v_t'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int k0;
    int d0;
    snk.valid = 1'b0;
    snk.data = '0;
    snk.startofpacket = 1'b0;
    snk.endofpacket = 1'b0;
    snk.empty = '0;
    snk.channel = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_src_valid", v_t'(src.valid), v_t'(0));
    check("rst_snk_ready", v_t'(snk.ready), v_t'(0));
    check("rst_pulses", v_t'({kept, drop}), v_t'(0));
    @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("rst_src_word", cur, v_t'(0));
    check("rst_src_channel", v_t'(src.channel), v_t'(0));
    check("rst_snk_ready_rel", v_t'(snk.ready), v_t'(1));
    idle(1);

    k0 = n_kept;
    d0 = n_drop;
    for (int i = 0; i < 4; i++)
      send_beat(pat(1, i), i == 0, i == 3,
                (i == 3) ? 3'd3 : 3'd0, i >= 2, 1'b1);
    lat_check("keep");
    wait_drain("keep_drain");
    check("keep_kept", v_t'(n_kept - k0), v_t'(1));
    check("keep_drop", v_t'(n_drop - d0), v_t'(0));

    k0 = n_kept;
    d0 = n_drop;
    send_pkt(2, 4, 1'b0, 1'b0);
    send_pkt(3, 2, 1'b1, 1'b1);
    wait_drain("drop_drain");
    check("drop_drop", v_t'(n_drop - d0), v_t'(1));
    check("drop_kept", v_t'(n_kept - k0), v_t'(1));

    k0 = n_kept;
    d0 = n_drop;
    stalls = 0;
    send_pkt(4, 10, 1'b1, 1'b0);
    idle(4);
    check("ovs_stalls", v_t'(stalls), v_t'(0));
    check("ovs_drop", v_t'(n_drop - d0), v_t'(1));
    check("ovs_kept", v_t'(n_kept - k0), v_t'(0));
    rdy_fixed = 1'b0;
    stalls = 0;
    send_pkt(5, DEPTH, 1'b1, 1'b1);
    idle(2);
    check("fit_stalls", v_t'(stalls), v_t'(0));
    check("fit_kept", v_t'(n_kept - k0), v_t'(1));
    rdy_fixed = 1'b1;
    wait_drain("fit_drain");

    rdy_fixed = 1'b0;
    send_pkt(6, 3, 1'b1, 1'b1);
    stalls = 0;
    for (int i = 0; i < 5; i++)
      send_beat(pat(7, i), i == 0, 1'b0, '0, 1'b0, 1'b1);
    check("fill_stalls", v_t'(stalls), v_t'(0));
    @(negedge clk);
    check("full_ready_low", v_t'(snk.ready), v_t'(0));
    idle(3);
    @(negedge clk);
    check("full_ready_hold", v_t'(snk.ready), v_t'(0));
    @(posedge clk);
    #1 rdy_fixed = 1'b1;
    send_beat(pat(7, 5), 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    wait_drain("fill_drain");

    k0 = n_kept;
    tog_en = 1'b1;
    for (int p = 8; p < 12; p++)
      send_pkt(p, 3, 1'b1, 1'b1);
    wait_drain("tog_drain");
    tog_en = 1'b0;
    check("tog_kept", v_t'(n_kept - k0), v_t'(4));

    k0 = n_kept;
    d0 = n_drop;
    send_beat(pat(12, 0), 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    idle(3);
    check("nosop_pulses", v_t'((n_kept - k0) + (n_drop - d0)), v_t'(0));
    send_beat(pat(13, 0), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    send_beat(pat(13, 1), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    send_pkt(14, 3, 1'b1, 1'b1);
    wait_drain("trunc_drain");
    check("trunc_drop", v_t'(n_drop - d0), v_t'(1));
    check("trunc_kept", v_t'(n_kept - k0), v_t'(1));

    rdy_fixed = 1'b0;
    send_pkt(15, 2, 1'b1, 1'b0);
    send_pkt(16, 2, 1'b1, 1'b0);
    idle(2);
    check("pend_valid", v_t'(src.valid), v_t'(1));
    k0 = n_kept;
    d0 = n_drop;
    srst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mrst_src_valid", v_t'(src.valid), v_t'(0));
    check("mrst_snk_ready", v_t'(snk.ready), v_t'(0));
    @(posedge clk);
    #1 srst = 1'b0;
    rdy_fixed = 1'b1;
    idle(10);
    check("mrst_empty", v_t'(src.valid), v_t'(0));
    check("mrst_pulses", v_t'((n_kept - k0) + (n_drop - d0)), v_t'(0));
    for (int i = 0; i < 3; i++)
      send_beat(pat(17, i), i == 0, i == 2, '0, i == 2, 1'b1);
    lat_check("mrst_lat");
    wait_drain("mrst_drain");

    check("sb_empty", v_t'(sb.size()), v_t'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_filter.md
# packet_filter

Store-and-forward packet filter downstream of the pattern classifier. It consumes the classified Avalon-ST stream, buffers each packet whole, and decides on the end-of-packet beat: a packet whose `channel` is nonzero on its eop beat is committed and forwarded; any other packet is discarded. Oversized and malformed packets are dropped, and each decision is reported with a one-cycle status pulse.

## Interface
Parameters:
- `AST_DWIDTH`, 64: Avalon-ST data width.
- `CHANNEL_WIDTH`, 1: sink channel width.
- `BUF_DEPTH`, 256: buffer depth in words; must be a power of two and at least 4.
- `EMPTY_WIDTH`, derived as `$clog2(AST_DWIDTH/8)`.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`, input, 1: clock.
- `srst_i`, input, 1: synchronous reset, active-high.
- `sink_if`, `avalon_st_if.sink`: classified input stream (data, valid, ready, startofpacket, endofpacket, empty, channel).
- `src_if`, `avalon_st_if.src`: filtered output stream; `channel` is tied to `'0`.
- `pkt_kept_o`, output, 1: one-cycle pulse, packet committed.
- `pkt_drop_o`, output, 1: one-cycle pulse, packet discarded (channel zero, oversize, or truncated).

## Operation
- Buffer word layout: {data, sop, eop, empty}, written at `wr_ptr`.
- Pointers `wr_ptr`, `commit_ptr` and `rd_ptr` are each `$clog2(BUF_DEPTH)+1` bits and wrap naturally. Fill level is `wr_ptr - rd_ptr`; the buffer is full when fill equals `BUF_DEPTH`.
- A beat is accepted when sink valid and sink ready are both high.
- Write FSM states:
  - **IDLE**
    - Accepted beat with sop: write it, go to STORE.
    - Accepted beat without sop: discard it silently (no pulse).
    - Single-beat packet (sop and eop together): decide immediately, as for eop in STORE.
  - **STORE**
    - Each accepted beat is written and `wr_ptr` increments.
    - On eop with nonzero channel: set `commit_ptr` to `wr_ptr+1`, pulse `pkt_kept_o`, go to IDLE.
    - On eop with zero channel: set `wr_ptr` back to `commit_ptr`, pulse `pkt_drop_o`, go to IDLE.
    - On sop without a preceding eop: roll back and pulse `pkt_drop_o` for the truncated packet; the new beat is then written at `commit_ptr` and the FSM stays in STORE.
    - Full with `wr_ptr - commit_ptr == BUF_DEPTH` (packet larger than the buffer): roll back, go to DROP. No pulse is issued yet.
  - **DROP**
    - Sink ready is forced to 1 and all beats are discarded.
    - On accepted eop: pulse `pkt_drop_o`, go to IDLE.
    - On accepted sop: pulse `pkt_drop_o`, treat the beat as an IDLE sop.
- Sink ready is `!full` in IDLE and STORE, 1 in DROP, and 0 while `srst_i` is high.
- Read side:
  - Reads only committed words, while `rd_ptr != commit_ptr`.
  - Buffer RAM has a 1-cycle read latency and feeds an output register followed by a 1-entry skid.
  - Together these sustain one beat per cycle while src ready is high.
  - `src_if` fields come from the output register; `empty` passes through unchanged.
- Uncommitted words are never visible on src.

## Timing
- Reset values: `src_if.valid`=0, `src_if.channel`=0, sop/eop/empty/data=0, `pkt_kept_o`=0, `pkt_drop_o`=0. All pointers are 0 and the FSM is in IDLE.
- Reset asserted mid-packet drops everything, including committed words, with no pulse.
- Decision pulses are registered and high in the cycle after the deciding beat is accepted.
- Latency: when src is idle and ready, the first beat of a kept packet is valid on src 2 cycles after the clock edge at which its eop was accepted. Following beats follow back-to-back.
- Src handshake:
  - Valid holds, with data stable, until ready is high.
  - Valid never depends combinationally on src ready.
- Sink handshake: ready depends only on registered state.
- Simultaneous eop accept (commit) and src read on the same cycle: both take effect. The read side sees the new `commit_ptr` one cycle later.
- Full and a read on the same cycle: ready is computed from registered fill, so a slot freed this cycle is usable from the next cycle.
- Throughput: 1 beat per cycle in, 1 beat per cycle out, concurrently.

## Structure
- `packet_filter_pkg`:
  - `filter_state_t` enum: IDLE, STORE, DROP.
  - `buf_word_t` packed struct: data, sop, eop, empty. Parameterized by `AST_DWIDTH` via package parameters, or defined locally if the package must stay unparameterized.
- Sub-module `pkt_buf_ram`: simple dual-port RAM, one write port and one read port, registered read, inferred memory, no reset on the array.

## Test plan
- **Keep packet.** 4-beat packet with channel 0,0,1,1 (eop channel 1), `empty`=3 on eop, src ready high → one `pkt_kept_o` pulse; identical 4 beats on src, starting 2 cycles after eop, with `empty`=3.
- **Drop packet.** 4-beat packet with eop channel 0 → one `pkt_drop_o` pulse; src stays silent. A following kept 2-beat packet appears intact.
- **Oversize.** `BUF_DEPTH`=8, 10-beat packet, channel 1 → FSM enters DROP after 8 writes and sink ready stays high; one `pkt_drop_o` pulse on eop; nothing on src; fill returns to 0.
- **Backpressure and fill.** Kept 3-beat packets sent back-to-back with src ready toggling 1010… → no loss or duplication. Sink ready drops when 8 words are held (3 committed, 5 uncommitted) and recovers as src drains.
- **Malformed input.**
  - A beat without sop in IDLE is ignored.
  - sop, then a second sop before eop → one drop pulse for the first packet; the second packet is kept if its eop channel is 1.
- **Reset mid-operation.** Assert `srst_i` with 2 committed packets pending → the next cycle shows `src_if.valid`=0 and sink ready=0; after release the buffer is empty and a new packet passes with normal latency.
